// File: rtl/part_74s299_if.sv
// Control and serial-port bundle for the part_74s299 shift/storage register.
// master: mode/serial/enable drivers, reads Q0S/Q7S; slave: the register.
interface part_74s299_if;
  logic S0;
  logic S1;
  logic DSR;
  logic DSL;
  logic OE1_N;
  logic OE2_N;
  logic Q0S;
  logic Q7S;

  modport master (
    output S0, S1, DSR, DSL, OE1_N, OE2_N,
    input  Q0S, Q7S
  );

  modport slave (
    input  S0, S1, DSR, DSL, OE1_N, OE2_N,
    output Q0S, Q7S
  );
endinterface

// File: rtl/part_74s299.sv
// 74S299-style universal shift/storage register on a shared tri-state bus.
// Ports: CLK, RESET_N (async, active low), bus (mode/serial/enables/Q0S/Q7S), IO (inout bus).
module part_74s299 #(
  parameter int WIDTH     = 8,
  parameter int REG_DELAY = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  part_74s299_if.slave     bus,
  inout  wire  [WIDTH-1:0] IO
);

  // Zero-delay register model; REG_DELAY only describes the part's timing.
  if (WIDTH < 2 || REG_DELAY < 0) begin : g_bad_param
    $error("part_74s299: WIDTH must be >= 2 and REG_DELAY >= 0");
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [1:0]       mode;
  logic             drive;

  assign mode = {bus.S1, bus.S0};

  always_comb begin
    r_d = r_q;
    unique case (mode)
      2'b00: r_d = r_q;
      2'b01: r_d = {r_q[WIDTH-2:0], bus.DSR};
      2'b10: r_d = {bus.DSL, r_q[WIDTH-1:1]};
      2'b11: r_d = IO;
      default: r_d = r_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  // Load mode always releases the bus so the part never loads itself.
  assign drive = !bus.OE1_N && !bus.OE2_N && (mode != 2'b11);

  assign IO      = drive ? r_q : {WIDTH{1'bz}};
  assign bus.Q0S = r_q[0];
  assign bus.Q7S = r_q[WIDTH-1];

endmodule

// File: tb/tb_part_74s299.sv
// Scoreboard bench for part_74s299: directed vectors push expectations,
// a monitor samples IO/Q0S/Q7S and compares. IO has pull-ups (Z reads FF).
module tb_part_74s299;

  typedef struct {
    string    name;
    logic [7:0] io;
    logic     q0;
    logic     q7;
  } exp_t;

  logic CLK;
  logic RESET_N;
  logic tb_drv;
  logic [7:0] tb_val;
  wire  [7:0] io_bus;

  int checks;
  int passes;
  exp_t sb[$];
  event sample_ev;

  part_74s299_if bus ();

  part_74s299 #(.WIDTH(8), .REG_DELAY(1)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave),
    .IO      (io_bus)
  );

  assign io_bus = tb_drv ? tb_val : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (io_bus[g]);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: pops expectations whenever the stimulus presents a sample point.
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (io_bus === e.io) passes++;
        else $display("FAIL %s IO got %h want %h", e.name, io_bus, e.io);
        checks++;
        if (bus.Q0S === e.q0) passes++;
        else $display("FAIL %s Q0S got %b want %b", e.name, bus.Q0S, e.q0);
        checks++;
        if (bus.Q7S === e.q7) passes++;
        else $display("FAIL %s Q7S got %b want %b", e.name, bus.Q7S, e.q7);
      end
    end
  end

  task automatic expect_now(input string nm, input logic [7:0] io,
                            input logic q0, input logic q7);
    exp_t e;
    e.name = nm;
    e.io   = io;
    e.q0   = q0;
    e.q7   = q7;
    sb.push_back(e);
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.S1 = m[1];
    bus.S0 = m[0];
  endtask

  // Parallel load from the bench driver; leaves mode 00, bus released.
  task automatic load(input logic [7:0] v);
    set_mode(2'b11);
    #1;
    tb_val = v;
    tb_drv = 1'b1;
    edge1();
    tb_drv = 1'b0;
    #1;
    set_mode(2'b00);
    #1;
  endtask

  logic [7:0] sr_tab [8];
  logic [7:0] sl_tab [8];

  initial begin
    checks = 0;
    passes = 0;
    tb_drv = 1'b0;
    tb_val = 8'h00;
    RESET_N = 1'b0;
    bus.S0 = 1'b0;
    bus.S1 = 1'b0;
    bus.DSR = 1'b0;
    bus.DSL = 1'b0;
    bus.OE1_N = 1'b0;
    bus.OE2_N = 1'b0;

    sr_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    sl_tab = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    // Reset held, enabled, hold mode.
    edge1();
    edge1();
    expect_now("reset_hold", 8'h00, 1'b0, 1'b0);
    RESET_N = 1'b1;
    edge1();

    // Load A5; block must not drive in load mode.
    set_mode(2'b11);
    #1;
    tb_val = 8'hA5;
    tb_drv = 1'b1;
    edge1();
    tb_drv = 1'b0;
    expect_now("load_released", 8'hFF, 1'b1, 1'b1);
    set_mode(2'b00);
    expect_now("load_drive", 8'hA5, 1'b1, 1'b1);

    // Reset pulse between edges clears without a clock.
    RESET_N = 1'b0;
    #1;
    RESET_N = 1'b1;
    expect_now("reset_pulse", 8'h00, 1'b0, 1'b0);

    // Shift right from 81 with DSR=0.
    load(8'h81);
    expect_now("sr_load", 8'h81, 1'b1, 1'b1);
    bus.DSR = 1'b0;
    set_mode(2'b01);
    for (int k = 0; k < 8; k++) begin
      edge1();
      expect_now($sformatf("sr_edge%0d", k + 1), sr_tab[k],
                 sr_tab[k][0], sr_tab[k][7]);
    end
    set_mode(2'b00);

    // Shift left from 01 with DSL=1.
    load(8'h01);
    bus.DSL = 1'b1;
    set_mode(2'b10);
    for (int k = 0; k < 8; k++) begin
      edge1();
      expect_now($sformatf("sl_edge%0d", k + 1), sl_tab[k],
                 sl_tab[k][0], sl_tab[k][7]);
    end
    set_mode(2'b00);
    bus.DSL = 1'b0;

    // Enable gating with R=3C.
    load(8'h3C);
    for (int c = 0; c < 4; c++) begin
      logic [1:0] oe;
      oe = c[1:0];
      bus.OE1_N = oe[1];
      bus.OE2_N = oe[0];
      expect_now($sformatf("oe_%0d%0d", oe[1], oe[0]),
                 (oe == 2'b00) ? 8'h3C : 8'hFF, 1'b0, 1'b0);
    end
    bus.OE1_N = 1'b0;
    bus.OE2_N = 1'b0;
    set_mode(2'b11);
    expect_now("mode11_release", 8'hFF, 1'b0, 1'b0);
    set_mode(2'b00);
    expect_now("mode00_redrive", 8'h3C, 1'b0, 1'b0);

    // Reset in the middle of a shift sequence.
    load(8'hFF);
    bus.DSR = 1'b0;
    set_mode(2'b01);
    edge1();
    edge1();
    set_mode(2'b00);
    expect_now("mid_shift", 8'hFC, 1'b0, 1'b1);
    RESET_N = 1'b0;
    expect_now("mid_reset", 8'h00, 1'b0, 1'b0);
    RESET_N = 1'b1;
    bus.DSR = 1'b1;
    set_mode(2'b01);
    edge1();
    set_mode(2'b00);
    expect_now("resume_sr", 8'h01, 1'b1, 1'b0);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 20 && sb.size() > 0; t++) begin
      #1;
      ->sample_ev;
    end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain %0d left want 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/part_74s299.md
# part_74s299

8-bit universal shift/storage register with a shared three-state I/O bus, modelled on the 74S299. It is the bus-side counterpart to the octal 74S374 output register. A 374 drives a byte onto a shared data bus; this block captures that byte from the bus, shifts it in either direction, and can later drive its own contents back onto the same pins. It sits on CADR shared data paths wherever a bus value must be captured, serialised, or returned.

## Interface
Parameters:
- WIDTH, 8, register and bus width; must be ≥ 2
- REG_DELAY, 1, clock-to-output and enable-to-output delay in simulation time units

Ports:
- CLK  input  1  clock; all state changes occur on the rising edge
- RESET_N  input  1  asynchronous, active-low master reset; clears the register
- S0  input  1  mode select, low bit
- S1  input  1  mode select, high bit
- DSR  input  1  serial data in for shift-right (enters bit 0)
- DSL  input  1  serial data in for shift-left (enters bit WIDTH-1)
- OE1_N  input  1  output enable 1, active low
- OE2_N  input  1  output enable 2, active low
- IO  inout  WIDTH  shared bus; parallel-load source, and register output when enabled
- Q0S  output  1  serial out, always equals register bit 0
- Q7S  output  1  serial out, always equals register bit WIDTH-1

## Operation
- Internal state is one WIDTH-bit register R. There is no other state.
- Mode {S1,S0} is sampled on the CLK rising edge:
  - 00 hold: R unchanged.
  - 01 shift right: R[0] ← DSR; R[n] ← R[n-1] for n = 1..WIDTH-1.
  - 10 shift left: R[WIDTH-1] ← DSL; R[n] ← R[n+1] for n = 0..WIDTH-2.
  - 11 parallel load: R ← IO.
- Bus drive: IO = R only when OE1_N=0, OE2_N=0, and {S1,S0}≠11. In every other case IO is high-Z.
  - The mode term is combinational. In load mode the block always releases the bus, so it can never load its own output.
- RESET_N=0 sets R=0 immediately, independent of CLK and of the mode. Clock edges are ignored while reset is held.
- Reset does not affect output enables. If the block is enabled during reset, IO drives all zeros.
- Q0S and Q7S follow R continuously. They are never high-Z and are unaffected by OE1_N, OE2_N, or the mode.
- Reset output values: R=0, Q0S=0, Q7S=0. IO is 0 if enabled, otherwise high-Z.
- In load mode, an IO bit that is Z or X loads X into that bit of R. No X masking or substitution is performed.

## Timing
- Load and shift latency is one edge. R, Q0S, Q7S, and the driven IO update REG_DELAY after the CLK rising edge.
- Assertion of RESET_N=0 clears the outputs REG_DELAY later. Release of reset is asynchronous. The first edge after release acts normally. A release coincident with an edge does not have to capture that edge.
- Changing OE1_N, OE2_N, S0, or S1 moves IO between driven and high-Z after REG_DELAY, with no clock required.
- On a load edge, the IO value sampled is the value present at the edge. External drivers must hold IO valid across the edge.
- Back-to-back modes on consecutive edges are fully supported; there are no dead cycles.
- Reset asserted in the middle of a shift sequence discards the partial result. Resuming after release starts from R=0.

## Test plan
- Reset: hold RESET_N=0 with OE1_N=OE2_N=0 and mode 00 → IO=8'h00, Q0S=0, Q7S=0. Pulse reset between clock edges → clears without an edge.
- Load then drive:
  - Drive IO=8'hA5 with S1S0=11 and clock once. The bench must confirm IO stays undriven by the block throughout load mode.
  - Release the external driver, set mode 00 and OE1_N=OE2_N=0 → IO=8'hA5, Q0S=1, Q7S=1.
- Shift right: with R=8'h81, DSR=0, apply mode 01 for 1 edge → R=8'h02. After 7 more edges → R=8'h00, with Q7S=1 after the 7th edge in total.
- Shift left: with R=8'h01 and DSL=1, apply mode 10 for 8 edges → R=8'hFF. Q0S goes high after the 8th edge.
- Enable gating: with R=8'h3C, check each combination of OE1_N/OE2_N → IO=8'h3C only for 00, otherwise Z. Switching the mode to 11 with both enables low → IO becomes Z within REG_DELAY, with no clock.
- Reset mid-operation: load 8'hFF, shift right twice, then assert reset between edges → R=8'h00 immediately. The next shift-right edge with DSR=1 → R=8'h01.
